vga_scanout_fsm: RTL and testbench
==================================

Name: vga_scanout_fsm

Overview:
- Read-side counterpart of the PPU render FSM.
- Generates 640x480 VGA timing and scans the 256x240 PPU framebuffer out 2x-scaled (512x480, 64-px black borders left and right).
- Drives `vga_done` to grant the PPU the framebuffer during vertical blank. Takes it back at the start of a frame only once the PPU has signalled a completed frame.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- H_BORDER, 64, black columns each side of the picture
- SYNC_POL, 0, active level of hsync/vsync

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- pix_en  in  1  pixel-rate enable; all counters and pipeline advance only when high
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_row  out  9  framebuffer row, 0..239
- fb_rd_col  out  9  framebuffer column, 0..255
- fb_rd_data  in  8  palette index; valid one `pix_en` cycle after `fb_rd_en`
- ppu_frame_done  in  1  one-cycle pulse from the PPU when its frame is complete
- vga_done  out  1  high means the PPU owns the framebuffer
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- frame_skip_cnt  out  16  frames blanked because the PPU was not ready

Behaviour:
- Counters:
  - `hcnt` runs 0..H_TOT-1, where H_TOT = sum of the H parameters (800).
  - `vcnt` runs 0..V_TOT-1 (525).
  - `vcnt` increments when `hcnt` wraps; both wrap to 0.
  - Both advance only on `pix_en`.
- Active region: `vcnt` < V_VIS and H_BORDER <= `hcnt` < H_VIS-H_BORDER.
  - In the active region: `fb_rd_en`=1, `fb_rd_col`=(`hcnt`-H_BORDER)>>1, `fb_rd_row`=`vcnt`>>1.
  - Outside it: `fb_rd_en`=0 and row/col hold their previous values.
- Pipeline: 2 `pix_en` cycles total.
  - Stage 1: address issue, with hsync/vsync/active delayed to match.
  - Stage 2: `fb_rd_data`[5:0] goes through the palette LUT into the registered RGB outputs.
  - `vga_hsync`/`vga_vsync` are delayed 2 cycles so they stay aligned with RGB.
- Output values:
  - RGB = 0 outside the active region and whenever `scan_on`=0.
  - `fb_rd_data`[7:6] are ignored.
  - Sync is active (=SYNC_POL) for `hcnt` in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC), and likewise for `vcnt`.
- Frame handshake, states SCAN and BLANK:
  - `frame_ready` latch: set by `ppu_frame_done`, cleared when consumed.
  - At `hcnt`=0, `vcnt`=0 with `pix_en`:
    - If `frame_ready`, or `ppu_frame_done` in the same cycle: state <= SCAN, `vga_done` <= 0, `frame_ready` <= 0, `scan_on`=1.
    - Otherwise: state <= BLANK, `vga_done` stays 1, `scan_on`=0, `frame_skip_cnt` increments (saturating at 16'hFFFF), and no framebuffer reads are issued that frame (`fb_rd_en` forced 0).
  - SCAN -> BLANK on the `pix_en` cycle where `vcnt`=V_VIS-1 and `hcnt`=H_VIS-H_BORDER-1 (last read issued). `vga_done` <= 1 on the following `pix_en` cycle.
  - `ppu_frame_done` arriving during SCAN is latched (protocol violation, tolerated) and consumed at the next frame start.
- Reset:
  - `hcnt`=`vcnt`=0; state BLANK; `vga_done`=1; `frame_ready`=0.
  - Sync outputs inactive (=~SYNC_POL); RGB=0; `fb_rd_en`=0; `fb_rd_row`/`fb_rd_col`=0; `frame_skip_cnt`=0.
  - Reset mid-frame aborts the frame immediately. Because `frame_ready` is cleared, the first frame after reset is always blank.
- `pix_en` low: everything holds, including `vga_done` and the pipeline registers.

Decomposition:
- Shared package `vga_pkg` holds:
  - the timing constants and H_TOT/V_TOT;
  - NES_W=256, NES_H=240;
  - the state encoding (SCAN/BLANK).
- One sub-module, `nes_palette_lut`: combinational, 6-bit index to 12-bit RGB, 64-entry NES master palette.

Test Plan:
- Reset then free-run with `pix_en`=1 and no `ppu_frame_done` -> `vga_done` stays 1; RGB=0 whole frame; `frame_skip_cnt`=1 after the first frame start, then 2 at 420000 cycles later.
- Pulse `ppu_frame_done`, then reach frame start -> `vga_done` falls at `hcnt`=0/`vcnt`=0. First read has row=0, col=0 at `hcnt`=64; `hcnt`=65 still reads col=0, `hcnt`=66 reads col=1.
- Framebuffer model returns index 0x16 at (row 0, col 0) -> `vga_r/g/b` = LUT(0x16) two `pix_en` cycles after the read issue; columns 0..63 and 576..639 are black.
- End of scanned frame -> last read row=239, col=255 at `vcnt`=479, `hcnt`=575; `vga_done`=1 one cycle later. Hsync active for `hcnt` 656..751 and vsync for `vcnt` 490..491, both measured at the output with the 2-cycle delay.
- `ppu_frame_done` in the same cycle as frame start -> frame scanned and no skip counted. A pulse during SCAN -> next frame also scanned.
- Assert `rst` mid-scan at `vcnt`=200 -> next cycle shows `vga_done`=1, RGB=0, counters 0; following frame blank; toggle `pix_en` 1-of-4 and confirm identical output sequence, stretched 4x.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: 640x480 timing, NES framebuffer geometry, state encoding.
package vga_pkg;

  localparam int H_VIS    = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_VIS    = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_BORDER = 64;
  localparam logic SYNC_POL = 1'b0;

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int NES_W = 256;
  localparam int NES_H = 240;

  localparam int CNT_W = 10;

  typedef logic [11:0] rgb12_t;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

endpackage

// File: rtl/nes_palette_lut.sv
// NES 2C02 master palette: 6-bit palette index to 4:4:4 RGB, purely combinational.
module nes_palette_lut
  import vga_pkg::*;
(
  input  logic [5:0] idx,
  output rgb12_t     rgb
);

  localparam rgb12_t PAL [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

  assign rgb = PAL[idx];

endmodule

// File: rtl/vga_scanout_fsm.sv
// VGA 640x480 timing plus 2x-scaled readout of the 256x240 PPU framebuffer,
// with a per-frame handshake that hands the framebuffer to the PPU during blank.
//
// state | meaning
// SCAN  | frame is being read out; PPU locked out (vga_done=0)
// BLANK | no reads issued; vga_done=1 so the PPU may render
module vga_scanout_fsm #(
  parameter int   H_VIS    = vga_pkg::H_VIS,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_VIS    = vga_pkg::V_VIS,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter int   H_BORDER = vga_pkg::H_BORDER,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic        fb_rd_en,
  output logic [8:0]  fb_rd_row,
  output logic [8:0]  fb_rd_col,
  input  logic [7:0]  fb_rd_data,
  input  logic        ppu_frame_done,
  output logic        vga_done,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic [15:0] frame_skip_cnt
);
  import vga_pkg::*;

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] ACT_BEG = 10'(H_BORDER);
  localparam logic [9:0] ACT_END = 10'(H_VIS - H_BORDER);
  localparam logic [9:0] V_ACT   = 10'(V_VIS);

  logic [9:0]  hcnt, vcnt, col_off;
  scan_state_t state;
  logic        frame_ready;
  logic        hs1, vs1, act1;
  logic        frame_start, in_active, rd_now, last_read, hs_now, vs_now;
  rgb12_t      pal_rgb;
  logic        unused_idx_hi;

  assign frame_start   = (hcnt == '0) && (vcnt == '0);
  assign in_active     = (vcnt < V_ACT) && (hcnt >= ACT_BEG) && (hcnt < ACT_END);
  assign rd_now        = in_active && (state == SCAN);
  assign last_read     = (vcnt == V_ACT - 10'd1) && (hcnt == ACT_END - 10'd1);
  assign hs_now        = ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_now        = ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign col_off       = hcnt - ACT_BEG;
  assign unused_idx_hi = ^fb_rd_data[7:6];

  nes_palette_lut u_palette (
    .idx (fb_rd_data[5:0]),
    .rgb (pal_rgb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt           <= '0;
      vcnt           <= '0;
      state          <= BLANK;
      vga_done       <= 1'b1;
      frame_ready    <= 1'b0;
      frame_skip_cnt <= '0;
      fb_rd_en       <= 1'b0;
      fb_rd_row      <= '0;
      fb_rd_col      <= '0;
      hs1            <= ~SYNC_POL;
      vs1            <= ~SYNC_POL;
      act1           <= 1'b0;
      vga_hsync      <= ~SYNC_POL;
      vga_vsync      <= ~SYNC_POL;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      // The PPU pulse is latched at clock rate so it is not lost while pix_en is low.
      if (ppu_frame_done) frame_ready <= 1'b1;

      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end

        fb_rd_en <= rd_now;
        act1     <= rd_now;
        hs1      <= hs_now;
        vs1      <= vs_now;
        if (rd_now) begin
          fb_rd_row <= 9'(vcnt >> 1);
          fb_rd_col <= 9'(col_off >> 1);
        end

        vga_hsync <= hs1;
        vga_vsync <= vs1;
        {vga_r, vga_g, vga_b} <= act1 ? pal_rgb : '0;

        if (frame_start) begin
          if (frame_ready || ppu_frame_done) begin
            state       <= SCAN;
            vga_done    <= 1'b0;
            frame_ready <= 1'b0;
          end else begin
            state <= BLANK;
            if (frame_skip_cnt != 16'hFFFF) frame_skip_cnt <= frame_skip_cnt + 16'd1;
          end
        end else if ((state == SCAN) && last_read) begin
          state <= BLANK;
        end else if ((state == BLANK) && !vga_done) begin
          vga_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout_fsm.sv
// Directed bench for vga_scanout_fsm; full horizontal timing, vertical timing shortened to 10 lines.
module tb_vga_scanout_fsm;

  localparam int HT = 800;
  localparam int VT = 10;
  localparam int F  = HT * VT;

  logic        clk = 1'b0;
  logic        rst, pix_en, ppu_frame_done;
  logic        fb_rd_en, vga_done, vga_hsync, vga_vsync;
  logic [8:0]  fb_rd_row, fb_rd_col;
  logic [7:0]  fb_rd_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [15:0] frame_skip_cnt;

  always #5 clk = ~clk;

  vga_scanout_fsm #(.V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_en         (pix_en),
    .fb_rd_en       (fb_rd_en),
    .fb_rd_row      (fb_rd_row),
    .fb_rd_col      (fb_rd_col),
    .fb_rd_data     (fb_rd_data),
    .ppu_frame_done (ppu_frame_done),
    .vga_done       (vga_done),
    .vga_hsync      (vga_hsync),
    .vga_vsync      (vga_vsync),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .frame_skip_cnt (frame_skip_cnt)
  );

  // Framebuffer model: 0x16 at the origin, elsewhere top bits set (must be ignored) over col^row.
  always_comb begin
    fb_rd_data = {2'b11, fb_rd_col[5:0] ^ fb_rd_row[5:0]};
    if (fb_rd_row == 9'd0 && fb_rd_col == 9'd0) fb_rd_data = 8'h16;
  end

  int errors = 0;
  int checks = 0;
  int p      = 0;
  int div    = 1;
  int hold_bad = 0;
  logic activity;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int at(input int h, input int v, input int fr);
    return fr * F + v * HT + h;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({vga_done, vga_hsync, vga_vsync, fb_rd_en, fb_rd_row, fb_rd_col,
                vga_r, vga_g, vga_b, frame_skip_cnt});
  endfunction

  function automatic logic [31:0] rgb();
    return 32'({vga_r, vga_g, vga_b});
  endfunction

  // One pixel step: div-1 idle clocks (outputs must hold) then one pix_en clock.
  task automatic step();
    logic [63:0] snap;
    for (int i = 1; i < div; i++) begin
      pix_en = 1'b0;
      snap = outs();
      @(posedge clk); #1;
      if (outs() !== snap) hold_bad++;
    end
    pix_en = 1'b1;
    @(posedge clk); #1;
    p++;
    if (fb_rd_en || rgb() != 0 || !vga_done) activity = 1'b1;
  endtask

  task automatic run_to(input int t);
    while (p < t) step();
  endtask

  task automatic pulse_done();
    ppu_frame_done = 1'b1;
    step();
    ppu_frame_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b1; ppu_frame_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", vga_done, 1);
    chk("rst_rd_en", fb_rd_en, 0);
    chk("rst_rgb", rgb(), 0);
    chk("rst_hsync", vga_hsync, 1);
    chk("rst_vsync", vga_vsync, 1);
    chk("rst_row", fb_rd_row, 0);
    chk("rst_col", fb_rd_col, 0);
    chk("rst_skip", frame_skip_cnt, 0);

    // Frame 0 and 1: no PPU frame, both blanked.
    rst = 1'b0; p = 0; activity = 1'b0;
    run_to(1);
    chk("skip_first", frame_skip_cnt, 1);
    run_to(at(655, 0, 0) + 2); chk("hs_655", vga_hsync, 1);
    run_to(at(656, 0, 0) + 2); chk("hs_656", vga_hsync, 0);
    run_to(at(751, 0, 0) + 2); chk("hs_751", vga_hsync, 0);
    run_to(at(752, 0, 0) + 2); chk("hs_752", vga_hsync, 1);
    run_to(at(799, 6, 0) + 2); chk("vs_6", vga_vsync, 1);
    run_to(at(0, 7, 0) + 2);   chk("vs_7", vga_vsync, 0);
    run_to(at(799, 8, 0) + 2); chk("vs_8", vga_vsync, 0);
    run_to(at(0, 9, 0) + 2);   chk("vs_9", vga_vsync, 1);
    run_to(F);
    chk("blank_activity", activity, 0);
    run_to(F + 1);
    chk("skip_second", frame_skip_cnt, 2);

    // PPU completes during frame 1 -> frame 2 scanned.
    run_to(F + 3000);
    pulse_done();
    run_to(2 * F);                chk("done_pre_start", vga_done, 1);
    run_to(2 * F + 1);            chk("done_fall", vga_done, 0);
    chk("skip_hold", frame_skip_cnt, 2);
    run_to(at(63, 0, 2) + 1);     chk("rd_en_63", fb_rd_en, 0);
    run_to(at(64, 0, 2) + 1);
    chk("rd_en_64", fb_rd_en, 1);
    chk("row_64", fb_rd_row, 0);
    chk("col_64", fb_rd_col, 0);
    chk("rgb_63", rgb(), 0);
    run_to(at(64, 0, 2) + 2);
    chk("rgb_64", rgb(), 32'hF30);
    chk("col_65", fb_rd_col, 0);
    run_to(at(66, 0, 2) + 1);
    chk("col_66", fb_rd_col, 1);
    chk("rgb_65", rgb(), 32'hF30);
    run_to(at(66, 0, 2) + 2);     chk("rgb_66", rgb(), 32'h00F);
    run_to(at(148, 0, 2) + 2);    chk("rgb_148", rgb(), 32'h5D5);
    run_to(at(576, 0, 2) + 1);
    chk("rd_en_576", fb_rd_en, 0);
    chk("col_hold", fb_rd_col, 255);
    run_to(at(577, 0, 2) + 2);    chk("rgb_577", rgb(), 0);
    run_to(at(64, 2, 2) + 1);     chk("row_line2", fb_rd_row, 1);
    run_to(at(575, 5, 2) + 1);
    chk("last_rd_en", fb_rd_en, 1);
    chk("last_row", fb_rd_row, 2);
    chk("last_col", fb_rd_col, 255);
    chk("last_done", vga_done, 0);
    run_to(at(575, 5, 2) + 2);
    chk("end_done", vga_done, 1);
    chk("end_rd_en", fb_rd_en, 0);
    chk("end_rgb", rgb(), 32'hFDF);

    // Pulse coincident with frame start, then a pulse during SCAN.
    run_to(3 * F);                chk("done_pre3", vga_done, 1);
    pulse_done();
    chk("same_cycle_done", vga_done, 0);
    chk("same_cycle_skip", frame_skip_cnt, 2);
    run_to(at(100, 1, 3));
    pulse_done();
    run_to(at(575, 5, 3) + 2);    chk("end3_done", vga_done, 1);
    run_to(4 * F + 1);
    chk("latched_done", vga_done, 0);
    chk("latched_skip", frame_skip_cnt, 2);

    // Reset in the middle of a scanned frame.
    run_to(at(300, 2, 4) + 1);    chk("pre_rst_rd", fb_rd_en, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_done", vga_done, 1);
    chk("mid_rst_rgb", rgb(), 0);
    chk("mid_rst_rd_en", fb_rd_en, 0);
    chk("mid_rst_hsync", vga_hsync, 1);
    chk("mid_rst_skip", frame_skip_cnt, 0);
    chk("mid_rst_hcnt", 32'(dut.hcnt), 0);
    chk("mid_rst_vcnt", 32'(dut.vcnt), 0);

    // Stretched run: pix_en 1-of-4, same timing in pixel steps.
    rst = 1'b0; p = 0; div = 4; activity = 1'b0;
    step();
    chk("st_skip", frame_skip_cnt, 1);
    chk("st_done", vga_done, 1);
    run_to(at(655, 0, 0) + 2); chk("st_hs_655", vga_hsync, 1);
    run_to(at(656, 0, 0) + 2); chk("st_hs_656", vga_hsync, 0);
    run_to(at(751, 0, 0) + 2); chk("st_hs_751", vga_hsync, 0);
    run_to(at(752, 0, 0) + 2); chk("st_hs_752", vga_hsync, 1);
    run_to(at(10, 1, 0));
    chk("st_vsync", vga_vsync, 1);
    chk("st_activity", activity, 0);
    chk("st_hold", hold_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
